// File: rtl/axis_i2c_pkg.sv
// rtl/axis_i2c_pkg.sv - shared stream widths, FIFO depth and beat type for the I2C stream path
package axis_i2c_pkg;

  localparam int AXIS_DATA_WIDTH = 8;
  localparam int AXIS_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                       tlast;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - simple dual-port array, synchronous write, asynchronous read
module axis_fifo_mem
  import axis_i2c_pkg::*;
#(
  parameter int WIDTH = $bits(axis_beat_t),
  parameter int DEPTH = AXIS_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // No reset on the array so it can map onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream FIFO with tlast framing, fill level and optional packet mode
module axis_fifo
  import axis_i2c_pkg::*;
#(
  parameter int DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int DEPTH       = AXIS_FIFO_DEPTH,
  parameter int PACKET_MODE = 0
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic [DATA_WIDTH-1:0]    m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   pkt_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [AW:0]         r_level;
  logic [AW:0]         r_pkt_cnt;
  logic                w_empty;
  logic                w_full;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_pkt_in;
  logic                w_pkt_out;
  logic [DATA_WIDTH:0] w_rd_data;

  // The extra pointer MSB is a wrap bit that distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign s_tready  = !w_full;
  assign w_wr_en   = s_tvalid && !w_full;
  assign w_rd_en   = m_tvalid && m_tready;
  assign w_pkt_in  = w_wr_en && s_tlast;
  assign w_pkt_out = w_rd_en && m_tlast;

  // Full escape lets an oversize packet drain instead of deadlocking.
  generate
    if (PACKET_MODE != 0) begin : g_packet
      assign m_tvalid = !w_empty && ((r_pkt_cnt != '0) || w_full);
    end else begin : g_stream
      assign m_tvalid = !w_empty;
    end
  endgenerate

  axis_fifo_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk     (clk_i),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data ({s_tlast, s_tdata}),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign {m_tlast, m_tdata} = w_rd_data;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_level   <= '0;
      r_pkt_cnt <= '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      case ({w_pkt_in, w_pkt_out})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + (AW+1)'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - (AW+1)'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  assign level_o   = r_level;
  assign pkt_cnt_o = r_pkt_cnt;

endmodule
